// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared width helper and spot-state encoding for the
//                parking-lot spot allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    // Encoding of one bit of the occupancy (F) vector
    localparam logic SPOT_FREE  = 1'b0;
    localparam logic SPOT_TAKEN = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_free_enc.sv
`default_nettype none
// ============================================================================
//  Module      : lowest_free_enc
//  Description : Combinational priority encoder returning the lowest-index
//                set bit of the free-spot vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module lowest_free_enc
    import parking_pkg::*;
#(
    parameter int N_SPOTS = 4,
    parameter int SEL_W   = (clog2(N_SPOTS) < 1) ? 1 : clog2(N_SPOTS)
) (
    input  logic [N_SPOTS-1:0] free_vec,
    output logic [SEL_W-1:0]   idx,
    output logic               any_free
);

    // Scan from the top down so the last hit (the lowest index) wins
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx      = SEL_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spot_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : spot_allocator
//  Description : Parking-lot occupancy manager. Allocates the lowest free
//                spot on entry, frees a named spot on exit, and keeps an
//                occupancy count with registered full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module spot_allocator
    import parking_pkg::*;
#(
    parameter int N_SPOTS = 4,
    parameter int SEL_W   = (clog2(N_SPOTS) < 1) ? 1 : clog2(N_SPOTS),
    parameter int CNT_W   = clog2(N_SPOTS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               En,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic [SEL_W-1:0]   exit_spot,
    output logic [N_SPOTS-1:0] F,
    output logic [N_SPOTS-1:0] E,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               entry_ack,
    output logic [SEL_W-1:0]   entry_spot,
    output logic               entry_nack,
    output logic               exit_ack,
    output logic               exit_err
);

    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(N_SPOTS);

    logic [N_SPOTS-1:0] r_f;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_entry_ack;
    logic [SEL_W-1:0]   r_entry_spot;
    logic               r_entry_nack;
    logic               r_exit_ack;
    logic               r_exit_err;

    logic [N_SPOTS-1:0] w_free_vec;
    logic [SEL_W-1:0]   w_free_idx;
    logic               w_any_free;
    logic               w_exit_hit;
    logic               w_entry_ok;
    logic               w_entry_nok;
    logic               w_exit_ok;
    logic               w_exit_nok;
    logic [N_SPOTS-1:0] w_f_next;
    logic [CNT_W-1:0]   w_count_next;

    assign w_free_vec = ~r_f;

    lowest_free_enc #(
        .N_SPOTS (N_SPOTS),
        .SEL_W   (SEL_W)
    ) u_enc (
        .free_vec (w_free_vec),
        .idx      (w_free_idx),
        .any_free (w_any_free)
    );

    // Exit target is occupied; indices >= N_SPOTS match no bit and read as free
    always_comb begin
        w_exit_hit = 1'b0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (exit_spot == SEL_W'(i)) begin
                w_exit_hit = (r_f[i] == SPOT_TAKEN);
            end
        end
    end

    // Request decode, all against the pre-edge occupancy
    always_comb begin
        w_entry_ok  = En & entry_req & w_any_free;
        w_entry_nok = En & entry_req & ~w_any_free;
        w_exit_ok   = En & exit_req & w_exit_hit;
        w_exit_nok  = En & exit_req & ~w_exit_hit;
    end

    // Next occupancy: the freed spot was taken and the granted spot was free,
    // so the two updates never touch the same bit
    always_comb begin
        w_f_next = r_f;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (w_exit_ok && (exit_spot == SEL_W'(i))) begin
                w_f_next[i] = SPOT_FREE;
            end
            if (w_entry_ok && (w_free_idx == SEL_W'(i))) begin
                w_f_next[i] = SPOT_TAKEN;
            end
        end
        w_count_next = r_count + CNT_W'(w_entry_ok) - CNT_W'(w_exit_ok);
    end

    // State and response registers; flags follow the next-state count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_f          <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_entry_ack  <= 1'b0;
            r_entry_spot <= '0;
            r_entry_nack <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_exit_err   <= 1'b0;
        end else begin
            r_f          <= w_f_next;
            r_count      <= w_count_next;
            r_full       <= (w_count_next == C_FULL_COUNT);
            r_empty      <= (w_count_next == '0);
            r_entry_ack  <= w_entry_ok;
            r_entry_nack <= w_entry_nok;
            r_exit_ack   <= w_exit_ok;
            r_exit_err   <= w_exit_nok;
            if (w_entry_ok) begin
                r_entry_spot <= w_free_idx;
            end
        end
    end

    assign F          = r_f;
    assign E          = ~r_f;
    assign count      = r_count;
    assign full       = r_full;
    assign empty      = r_empty;
    assign entry_ack  = r_entry_ack;
    assign entry_spot = r_entry_spot;
    assign entry_nack = r_entry_nack;
    assign exit_ack   = r_exit_ack;
    assign exit_err   = r_exit_err;

endmodule
`default_nettype wire

// File: tb/tb_spot_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spot_allocator
//  Description : Directed table-driven bench for spot_allocator (4 spots),
//                plus a 6-spot instance for out-of-range exit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spot_allocator;

    logic       CLK;
    logic       RST;

    // 4-spot instance
    logic       en4, ent4, ext4;
    logic [1:0] spot4;
    logic [3:0] f4, e4;
    logic [2:0] cnt4;
    logic       full4, empty4, eack4, nack4, xack4, xerr4;
    logic [1:0] espot4;

    // 6-spot instance
    logic       en6, ent6, ext6;
    logic [2:0] spot6;
    logic [5:0] f6, e6;
    logic [2:0] cnt6;
    logic       full6, empty6, eack6, nack6, xack6, xerr6;
    logic [2:0] espot6;

    int n_vec;
    int n_bad;

    spot_allocator #(.N_SPOTS(4)) dut4 (
        .CLK(CLK), .RST(RST), .En(en4), .entry_req(ent4), .exit_req(ext4),
        .exit_spot(spot4), .F(f4), .E(e4), .count(cnt4), .full(full4),
        .empty(empty4), .entry_ack(eack4), .entry_spot(espot4),
        .entry_nack(nack4), .exit_ack(xack4), .exit_err(xerr4)
    );

    spot_allocator #(.N_SPOTS(6)) dut6 (
        .CLK(CLK), .RST(RST), .En(en6), .entry_req(ent6), .exit_req(ext6),
        .exit_spot(spot6), .F(f6), .E(e6), .count(cnt6), .full(full6),
        .empty(empty6), .entry_ack(eack6), .entry_spot(espot6),
        .entry_nack(nack6), .exit_ack(xack6), .exit_err(xerr6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic       ent;
        logic       ext;
        logic [1:0] spot;
        logic [3:0] f;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       eack;
        logic [1:0] espot;
        logic       nack;
        logic       xack;
        logic       xerr;
    } vec_t;

    vec_t vecs[19];

    // Compare every 4-spot output against one expected record
    task automatic check4(input string name, input vec_t v);
        n_vec++;
        if (f4 !== v.f || e4 !== ~v.f || cnt4 !== v.cnt || full4 !== v.full ||
            empty4 !== v.empty || eack4 !== v.eack || espot4 !== v.espot ||
            nack4 !== v.nack || xack4 !== v.xack || xerr4 !== v.xerr) begin
            n_bad++;
            $display("FAIL %s: got F=%b E=%b cnt=%0d full=%b empty=%b eack=%b espot=%0d nack=%b xack=%b xerr=%b ; want F=%b E=%b cnt=%0d full=%b empty=%b eack=%b espot=%0d nack=%b xack=%b xerr=%b",
                     name, f4, e4, cnt4, full4, empty4, eack4, espot4, nack4, xack4, xerr4,
                     v.f, ~v.f, v.cnt, v.full, v.empty, v.eack, v.espot, v.nack, v.xack, v.xerr);
        end
    endtask

    task automatic check6(input string name, input logic [5:0] f, input logic [2:0] cnt,
                          input logic empty, input logic eack, input logic xack, input logic xerr);
        n_vec++;
        if (f6 !== f || e6 !== ~f || cnt6 !== cnt || empty6 !== empty || full6 !== 1'b0 ||
            eack6 !== eack || nack6 !== 1'b0 || xack6 !== xack || xerr6 !== xerr) begin
            n_bad++;
            $display("FAIL %s: got F=%b cnt=%0d empty=%b full=%b eack=%b nack=%b xack=%b xerr=%b ; want F=%b cnt=%0d empty=%b full=0 eack=%b nack=0 xack=%b xerr=%b",
                     name, f6, cnt6, empty6, full6, eack6, nack6, xack6, xerr6,
                     f, cnt, empty, eack, xack, xerr);
        end
    endtask

    initial begin
        vec_t rst_v;
        n_vec = 0;
        n_bad = 0;

        //            en ent ext spot  F        cnt   full empty eack espot nack xack xerr
        vecs[0]  = '{1'b1,1'b1,1'b0,2'd0,4'b0001,3'd1,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'd0,4'b0011,3'd2,1'b0,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,2'd0,4'b0111,3'd3,1'b0,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,2'd0,4'b1111,3'd4,1'b1,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'd0,4'b1111,3'd4,1'b1,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,2'd2,4'b1011,3'd3,1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,2'd0,4'b1111,3'd4,1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,2'd1,4'b1101,3'd3,1'b0,1'b0,1'b0,2'd2,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,2'd0,4'b1100,3'd2,1'b0,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,2'd2,4'b1000,3'd1,1'b0,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b1,2'd3,4'b0000,3'd0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,2'd3,4'b0000,3'd0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b0,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b0,2'd0,4'b0001,3'd1,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,2'd3,4'b0001,3'd1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1};
        vecs[14] = '{1'b0,1'b1,1'b1,2'd0,4'b0001,3'd1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b1,2'd0,4'b0001,3'd1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b1,1'b1,2'd0,4'b0001,3'd1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b1,1'b1,2'd0,4'b0010,3'd1,1'b0,1'b0,1'b1,2'd1,1'b0,1'b1,1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,2'd0,4'b0010,3'd1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0,1'b0};

        rst_v = '{1'b0,1'b0,1'b0,2'd0,4'b0000,3'd0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0};

        RST = 1'b1;
        en4 = 1'b0; ent4 = 1'b0; ext4 = 1'b0; spot4 = '0;
        en6 = 1'b0; ent6 = 1'b0; ext6 = 1'b0; spot6 = '0;
        @(negedge CLK);
        @(negedge CLK);
        check4("reset", rst_v);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Table: inputs driven just after an edge, outputs checked just after the next
        for (int i = 0; i < 19; i++) begin
            en4   = vecs[i].en;
            ent4  = vecs[i].ent;
            ext4  = vecs[i].ext;
            spot4 = vecs[i].spot;
            @(posedge CLK);
            #1;
            check4($sformatf("vec%0d", i), vecs[i]);
        end
        en4 = 1'b0; ent4 = 1'b0; ext4 = 1'b0;

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        #2;
        RST = 1'b1;
        #1;
        check4("async_reset", rst_v);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check4("post_reset_idle", rst_v);

        // First entry after reset goes to spot 0 again
        en4 = 1'b1; ent4 = 1'b1;
        @(posedge CLK);
        #1;
        check4("post_reset_entry", vecs[0]);
        en4 = 1'b0; ent4 = 1'b0;

        // 6-spot instance: out-of-range and free-spot exits are errors
        en6 = 1'b1; ent6 = 1'b1;
        @(posedge CLK);
        #1;
        check6("n6_entry", 6'b000001, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        ent6 = 1'b0; ext6 = 1'b1; spot6 = 3'd7;
        @(posedge CLK);
        #1;
        check6("n6_exit7", 6'b000001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        spot6 = 3'd6;
        @(posedge CLK);
        #1;
        check6("n6_exit6", 6'b000001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        spot6 = 3'd5;
        @(posedge CLK);
        #1;
        check6("n6_exit5_free", 6'b000001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        spot6 = 3'd0;
        @(posedge CLK);
        #1;
        check6("n6_exit0", 6'b000000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        en6 = 1'b0; ext6 = 1'b0;
        @(posedge CLK);
        #1;
        check6("n6_idle", 6'b000000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spot_allocator.md
Name: spot_allocator

Overview:
- Parametrised parking-lot occupancy manager for N_SPOTS spots.
- Keeps per-spot full (F) and empty (E) vectors, an occupancy count and full/empty lot flags.
- Automatically allocates the lowest-index free spot on an entry request. Frees a caller-named spot on an exit request.
- Sits between the gate/sensor controller and the display/billing logic; successor to the fixed 4-spot register.

Parameters:
- N_SPOTS, 4, number of spots tracked (1..64).
- SEL_W, clog2(N_SPOTS) (minimum 1), width of spot index ports.
- CNT_W, clog2(N_SPOTS+1), width of occupancy count.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- En  input  1  global enable; requests are ignored while low.
- entry_req  input  1  request to park one car.
- exit_req  input  1  request to release a spot.
- exit_spot  input  SEL_W  index of the spot being released.
- F  output  N_SPOTS  bit i = 1: spot i occupied.
- E  output  N_SPOTS  bit i = 1: spot i free; always equal to ~F.
- count  output  CNT_W  number of occupied spots.
- full  output  1  count == N_SPOTS.
- empty  output  1  count == 0.
- entry_ack  output  1  one-cycle pulse: entry granted.
- entry_spot  output  SEL_W  spot granted; valid when entry_ack = 1.
- entry_nack  output  1  one-cycle pulse: entry refused, lot full.
- exit_ack  output  1  one-cycle pulse: exit accepted.
- exit_err  output  1  one-cycle pulse: exit refused (spot already free or index out of range).

Behaviour:
- Reset (RST high, asynchronous):
  - F = 0, E = all ones, count = 0, empty = 1, full = 0.
  - entry_ack, entry_nack, exit_ack, exit_err = 0; entry_spot = 0.
  - RST mid-operation discards any request sampled on the same edge.
- Sampling and latency:
  - Requests are sampled on the rising CLK edge when En = 1 and RST = 0.
  - All outputs are registered; responses appear the cycle after sampling (1-cycle latency).
  - Ack/nack/err pulses last exactly one cycle.
  - Back-to-back requests every cycle are allowed.
- En = 0: no state change; all pulse outputs are 0 on the next cycle; F, E, count, full and empty hold.
- Entry:
  - Evaluated against pre-edge F.
  - If any bit of E is 1: set F[k] = 1 and E[k] = 0, where k is the lowest-index free spot. Assert entry_ack, drive entry_spot = k, count + 1.
  - Otherwise assert entry_nack; no state change.
- Exit:
  - If exit_spot < N_SPOTS and F[exit_spot] = 1: clear F[exit_spot], set E[exit_spot], assert exit_ack, count - 1.
  - Otherwise assert exit_err; no state change.
- Simultaneous entry and exit in one cycle:
  - Both are evaluated on pre-edge F.
  - A spot freed this cycle is not eligible for the same-cycle entry. When the lot is full, the entry is nacked even if the exit succeeds.
  - Both succeed: count unchanged; the freed spot and the allocated spot are always different.
  - Only one succeeds: count changes by ±1 accordingly.
- Count and flags:
  - count is a saturation-free up/down counter.
  - Invariant: count == popcount(F) at all times.
  - full and empty are derived from the next-state count and registered with it, so they never lag F.
- Wrap-around: none; count cannot exceed N_SPOTS or drop below 0 by construction.
- entry_spot holds its last granted value between grants.

Decomposition:
- Shared package parking_pkg:
  - Width helper function clog2.
  - Constants SPOT_FREE = 1'b0 and SPOT_TAKEN = 1'b1 for the F encoding.
- One sub-module, lowest_free_enc:
  - Combinational priority encoder over E, parametrised by N_SPOTS.
  - Outputs an index (SEL_W) and an any_free flag.
- The top level holds the F register, the counter, the request decode and the output registers.

Test Plan:
- Reset, N_SPOTS=4 -> F=0000, E=1111, count=0, empty=1, full=0, all pulses 0. Assert RST asynchronously mid-cycle -> outputs clear without waiting for an edge.
- Four consecutive entry_req cycles -> entry_spot = 0,1,2,3 with entry_ack each cycle. Afterwards F=1111, count=4, full=1. A fifth entry -> entry_nack=1 and F unchanged.
- From F=1111: exit_req with exit_spot=2 -> exit_ack, F=1011, count=3. Then entry_req -> entry_spot=2, F=1111.
- From F=1111: simultaneous entry_req and exit_req with exit_spot=1 -> exit_ack=1, entry_nack=1, F=1101, count=3.
- From F=0001: exit_req with exit_spot=3 (free) -> exit_err, no change. With N_SPOTS=6 and exit_spot=7 -> exit_err, no change.
- En=0 with entry_req and exit_req held high for 3 cycles -> no pulses and F/count stable. Raise En -> requests take effect on the next edge.
